processador_cpu_debug_ocimem_seq: RTL

Debug-memory access sequencer for the Nios II processor's on-chip debug path. Sits directly downstream of the CPU debug-slave wrapper's system-clock stage. It consumes the `jdo` payload and the `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a` strobes, and turns them into single-cycle reads and writes on a 256 x 32 debug RAM port. It returns `MonDReg` and `monitor_ready`/`monitor_error` to the debug slave for shift-out.

---
 rtl/processador_cpu_debug_ocimem_seq_if.sv | 25 ++
 rtl/processador_cpu_debug_ocimem_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/processador_cpu_debug_ocimem_seq_if.sv
// Debug RAM port bundle between the ocimem sequencer
// and the 256 x 32 on-chip debug memory.
interface processador_cpu_debug_ocimem_seq_if;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic        ram_re;

    modport master (
        output ram_addr,
        output ram_wdata,
        output ram_we,
        output ram_re,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_wdata,
        input  ram_we,
        input  ram_re,
        output ram_rdata
    );
endinterface

// File: rtl/processador_cpu_debug_ocimem_seq.sv
// Debug-memory access sequencer: turns debug-slave strobes
// into single-cycle reads/writes on the debug RAM port.
module processador_cpu_debug_ocimem_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    processador_cpu_debug_ocimem_seq_if.master ram,
    output logic [7:0]  MonAReg,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_REQ = 2'd1;
    localparam logic [1:0] RD_CAP = 2'd2;
    localparam logic [1:0] WR     = 2'd3;

    logic [1:0] state;
    logic       rd_next;
    logic       any_strobe;
    logic       unused_jdo;

    assign any_strobe = take_action_ocimem_a
                      | take_action_ocimem_b
                      | take_no_action_ocimem_a;
    assign unused_jdo = ^jdo[37:36];

    // Enables decode straight from state, so they are exclusive
    assign ram.ram_re    = (state == RD_REQ);
    assign ram.ram_we    = (state == WR);
    assign ram.ram_addr  = MonAReg;
    assign ram.ram_wdata = MonDReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_next       <= 1'b0;
            MonAReg       <= 8'd0;
            MonDReg       <= 32'd0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        MonAReg <= jdo[25:18];
                        rd_next <= 1'b0;
                        if (jdo[35])
                            monitor_error <= 1'b0;
                        if (jdo[17]) begin
                            state         <= RD_REQ;
                            monitor_ready <= 1'b0;
                        end else begin
                            monitor_ready <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        state         <= WR;
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        rd_next       <= 1'b1;
                        state         <= RD_REQ;
                        monitor_ready <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (any_strobe)
                        monitor_error <= 1'b1;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    if (any_strobe)
                        monitor_error <= 1'b1;
                    MonDReg <= ram.ram_rdata;
                    if (rd_next)
                        MonAReg <= MonAReg + 8'd1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                WR: begin
                    if (any_strobe)
                        monitor_error <= 1'b1;
                    MonAReg       <= MonAReg + 8'd1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
